// File: rtl/decode_dispatch_arbiter.sv
// Merges up to four format-decoder outputs into one in-order decode stream.
// Each decoder owns a one-entry slot; the oldest held instruction wins the registered output stage.
module decode_dispatch_arbiter #(
    parameter int numRequesters           = 4,
    parameter int grantIdxWidth           = 2,
    parameter int instructionCounterWidth = 64,
    parameter int payloadWidth            = 128
) (
    input  logic                                               clock_i,
    input  logic                                               reset_i,
    input  logic [numRequesters-1:0]                           req_enable_i,
    input  logic [numRequesters*instructionCounterWidth-1:0]   req_majId_i,
    input  logic [numRequesters*payloadWidth-1:0]              req_payload_i,
    output logic [numRequesters-1:0]                           req_stall_o,
    input  logic                                               stall_i,
    output logic                                               enable_o,
    output logic [instructionCounterWidth-1:0]                 majId_o,
    output logic [payloadWidth-1:0]                            payload_o,
    output logic [grantIdxWidth-1:0]                           grantIdx_o,
    output logic                                               overrun_o
);

    localparam int N  = numRequesters;
    localparam int IW = instructionCounterWidth;
    localparam int PW = payloadWidth;

    // Slot state
    logic [N-1:0]             r_slot_valid;
    logic [IW-1:0]            r_slot_maj_id  [N];
    logic [PW-1:0]            r_slot_payload [N];

    // Output stage
    logic                     r_out_valid;
    logic [IW-1:0]            r_maj_id;
    logic [PW-1:0]            r_payload;
    logic [grantIdxWidth-1:0] r_grant_idx;
    logic                     r_overrun;

    // Unpacked request fields and arbitration results
    logic [IW-1:0]            w_in_maj_id  [N];
    logic [PW-1:0]            w_in_payload [N];
    logic                     w_any_valid;
    logic [grantIdxWidth-1:0] w_win_idx;
    logic [IW-1:0]            w_win_maj_id;
    logic                     w_out_free;
    logic                     w_grant;
    logic [N-1:0]             w_granting;
    logic [N-1:0]             w_stall;
    logic [N-1:0]             w_capture;
    logic                     w_overrun_hit;

    // Requester 0 sits in the most-significant field of the packed buses.
    always_comb begin
        for (int n = 0; n < N; n++) begin
            w_in_maj_id[n]  = req_majId_i[(N-1-n)*IW +: IW];
            w_in_payload[n] = req_payload_i[(N-1-n)*PW +: PW];
        end
    end

    // Oldest-first selection; strict '<' while scanning upward keeps ties on the lowest index.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        w_any_valid  = 1'b0;
        w_win_idx    = '0;
        w_win_maj_id = '0;
        // NOTE: blocking assignments here are intentional: later iterations must see the running minimum.
        for (int n = 0; n < N; n++) begin
            if (r_slot_valid[n] && (!w_any_valid || (r_slot_maj_id[n] < w_win_maj_id))) begin
                w_any_valid  = 1'b1;
                w_win_idx    = grantIdxWidth'(n);
                w_win_maj_id = r_slot_maj_id[n];
            end
        end
    end

    assign w_out_free = !r_out_valid || !stall_i;
    assign w_grant    = w_out_free && w_any_valid;

    always_comb begin
        w_granting = '0;
        if (w_grant) begin
            w_granting[w_win_idx] = 1'b1;
        end
    end

    // A slot being drained this edge may accept a new entry on the same edge.
    assign w_stall       = r_slot_valid & ~w_granting;
    assign w_capture     = req_enable_i & ~w_stall;
    assign w_overrun_hit = |(req_enable_i & w_stall);

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            r_slot_valid <= '0;
            r_out_valid  <= 1'b0;
            r_maj_id     <= '0;
            r_payload    <= '0;
            r_grant_idx  <= '0;
            r_overrun    <= 1'b0;
        end else begin
            // Refill takes priority over the grant-clear of the same slot.
            r_slot_valid <= (r_slot_valid & ~w_granting) | w_capture;
            if (w_out_free) begin
                r_out_valid <= w_grant;
                if (w_grant) begin
                    r_maj_id    <= w_win_maj_id;
                    r_payload   <= r_slot_payload[w_win_idx];
                    r_grant_idx <= w_win_idx;
                end
            end
            if (w_overrun_hit) begin
                r_overrun <= 1'b1;
            end
        end
    end

    // NOTE: slot storage is qualified by r_slot_valid, so it is deliberately left out of reset.
    always_ff @(posedge clock_i) begin
        for (int n = 0; n < N; n++) begin
            if (w_capture[n]) begin
                r_slot_maj_id[n]  <= w_in_maj_id[n];
                r_slot_payload[n] <= w_in_payload[n];
            end
        end
    end

    assign req_stall_o = w_stall;
    assign enable_o    = r_out_valid;
    assign majId_o     = r_maj_id;
    assign payload_o   = r_payload;
    assign grantIdx_o  = r_grant_idx;
    assign overrun_o   = r_overrun;

endmodule

// File: doc/decode_dispatch_arbiter.md
# decode_dispatch_arbiter

Merges the outputs of up to four format-specific instruction decoders (D, DS, X, XO, …) into a single in-order decode stream for the backend. Each decoder gets a one-entry holding slot. Each cycle the arbiter grants the oldest held instruction (smallest major ID) into a registered output stage that honours downstream back-pressure. It sits between the format decoder bank and the dispatch/rename stage.

## Interface
Parameters:
- numRequesters, 4: number of decoder inputs.
- grantIdxWidth, 2: width of the granted-requester index; equals clog2(numRequesters).
- instructionCounterWidth, 64: major ID width.
- payloadWidth, 128: opaque decoded-instruction bundle width (opcode, address, unit type, operand flags, body).

Ports:
- clock_i  in  1  single clock; all state updates on the rising edge.
- reset_i  in  1  asynchronous, active-high reset.
- req_enable_i  in  numRequesters  per-decoder valid; bit 0 is requester 0.
- req_majId_i  in  numRequesters*instructionCounterWidth  packed major IDs; requester 0 occupies the most-significant field.
- req_payload_i  in  numRequesters*payloadWidth  packed payloads, same packing as req_majId_i.
- req_stall_o  out  numRequesters  per-decoder stall; combinational.
- stall_i  in  1  downstream stall.
- enable_o  out  1  output valid.
- majId_o  out  instructionCounterWidth  granted major ID.
- payload_o  out  payloadWidth  granted payload.
- grantIdx_o  out  grantIdxWidth  index of the requester that supplied the current output.
- overrun_o  out  1  sticky error flag.

## Operation
State:
- slotValid[n], slotMajId[n], slotPayload[n] for each requester n.
- Output register: outValid, majId_o, payload_o, grantIdx_o.
- Sticky overrun flag.

Control:
- outFree = !outValid || !stall_i.
- Grant occurs when outFree and at least one slotValid is set.
- Winner = valid slot with the smallest slotMajId, compared unsigned over the full width. Ties go to the lowest index.
- The major ID counter never wraps; no wrap-aware compare is required.
- granting[n] = grant this cycle && winner == n.

Per rising edge:
- On grant: output register loads the winner's slot, outValid=1, grantIdx_o=n, and slotValid[n] clears. A same-edge refill overrides the clear.
- outFree with no valid slot: outValid clears. majId_o, payload_o and grantIdx_o hold their last values.
- !outFree: the output register holds all fields unchanged.
- Slot capture: if req_enable_i[n] && !req_stall_o[n], slot n loads req_majId_i/req_payload_i field n and slotValid[n]=1.
- Overrun: req_enable_i[n] && req_stall_o[n] drops the input (slot unchanged) and sets overrun_o. overrun_o stays set until reset.

Combinational outputs:
- req_stall_o[n] = slotValid[n] && !granting[n]. A slot being granted accepts a new entry on the same edge, which gives full per-requester throughput.
- enable_o = outValid.

## Timing
- Reset (asynchronous assert, applies immediately): all slotValid=0, enable_o=0, majId_o=0, payload_o=0, grantIdx_o=0, overrun_o=0, req_stall_o=0. Slot data is don't-care.
- Reset asserted mid-stream discards all held and output instructions with no partial output.
- Latency: input presented before edge t is captured at edge t. If it is the oldest and outFree, it is granted at edge t+1; enable_o is high from t+1 until the next edge with stall_i low.
- Throughput: one instruction per cycle aggregate, and one per cycle per requester when stall_i=0 and that requester is always oldest.
- Downstream handshake: a transfer completes on an edge where enable_o && !stall_i. Outputs are stable while stall_i is high.
- Per-requester handshake: the decoder must hold off (not assert req_enable_i) while req_stall_o[n]=1.
- A newer instruction arriving in a slot does not pre-empt an older one; selection is re-evaluated every cycle over the current slots.
- All slots full while stall_i is high: all req_stall_o=1 and nothing is lost unless a decoder violates the stall.

## Test plan
- Reset mid-operation: fill slots 0–2, output valid, stall_i=1, assert reset_i between edges. All outputs and req_stall_o go to 0 immediately; after release with no inputs, enable_o stays 0.
- Single request: req_enable_i=4'b0001, majId=5, payload=0xA5 for one cycle. Two edges later enable_o=1, majId_o=5, payload_o=0xA5, grantIdx_o=0; one cycle later enable_o=0.
- Age ordering: one cycle with all four enabled, majIds {9,3,7,3} for requesters 0..3, stall_i=0. Outputs on consecutive cycles must be (3, idx1), (3, idx3), (7, idx2), (9, idx0).
- Back-pressure: output valid and stall_i=1 for 3 cycles while requesters 1 and 2 present IDs 10 and 11. Output is held, req_stall_o[1] and req_stall_o[2] go high, and nothing is dropped. After release, 10 then 11 appear on successive cycles.
- Overrun: drive req_enable_i[2]=1 while req_stall_o[2]=1 with majId 20. ID 20 never appears on majId_o, overrun_o=1, and it remains 1 after further traffic.
- Streaming: requester 0 alone, IDs 0..15 back-to-back, stall_i=0. req_stall_o[0] never asserts, and enable_o is high for 16 consecutive cycles carrying IDs 0..15 in order.
